row_shift_en_gen_p: RTL and testbench

ROW_SHIFT_EN_GEN_P -- requirements
Module: row_shift_en_gen_p

---
 rtl/row_shift_en_gen_p.sv | 149 ++++++++++++++
 tb/tb_row_shift_en_gen_p.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/row_shift_en_gen_p.sv
// Per-line shift-enable generator for a TAPS-wide pixel window: counts active pixels,
// then optionally drains the window with a tapering enable mask while padding is selected.
module row_shift_en_gen_p #(
    parameter int unsigned TAPS     = 11,
    parameter int unsigned COL_W    = 13,
    parameter int unsigned ACTIVE_W = 640,
    parameter bit          FLUSH_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             line_start,
    input  logic             pix_valid,
    output logic [TAPS-1:0]  shift_en,
    output logic             pad_sel,
    output logic [COL_W-1:0] col,
    output logic             line_done,
    output logic             overrun
);

    localparam int unsigned IDX_W = (TAPS > 2) ? $clog2(TAPS) : 1;

    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(ACTIVE_W - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(TAPS - 2);
    localparam logic [TAPS-1:0]  ALL_ONES   = {TAPS{1'b1}};
    // Flush cycle k enables taps above k only; shifting this base by k gives that mask.
    localparam logic [TAPS-1:0]  FLUSH_BASE = {{(TAPS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StFlush
    } state_e;

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TAPS-1:0]  shift_en_q, shift_en_d;
    logic             pad_sel_q, pad_sel_d;
    logic             line_done_q, line_done_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        idx_d       = idx_q;
        shift_en_d  = '0;
        pad_sel_d   = 1'b0;
        line_done_d = 1'b0;
        overrun_d   = 1'b0;

        if (!enable) begin
            state_d = StIdle;
            col_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (line_start) begin
                        state_d = StActive;
                        idx_d   = '0;
                        // A pixel arriving with line_start is pixel 0 of the new line.
                        if (pix_valid) begin
                            col_d      = COL_W'(1);
                            shift_en_d = ALL_ONES;
                        end else begin
                            col_d = '0;
                        end
                    end
                end

                StActive: begin
                    if (line_start) begin
                        // Restart wins over everything, including the last pixel.
                        col_d      = '0;
                        idx_d      = '0;
                        overrun_d  = 1'b1;
                        shift_en_d = pix_valid ? ALL_ONES : '0;
                    end else if (pix_valid) begin
                        shift_en_d = ALL_ONES;
                        col_d      = col_q + COL_W'(1);
                        if (col_q == LAST_COL) begin
                            idx_d = '0;
                            if (FLUSH_EN) begin
                                state_d = StFlush;
                            end else begin
                                state_d     = StIdle;
                                line_done_d = 1'b1;
                            end
                        end
                    end
                end

                StFlush: begin
                    if (line_start) begin
                        state_d    = StActive;
                        col_d      = '0;
                        idx_d      = '0;
                        overrun_d  = 1'b1;
                        shift_en_d = pix_valid ? ALL_ONES : '0;
                    end else begin
                        shift_en_d = FLUSH_BASE << idx_q;
                        pad_sel_d  = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d     = StIdle;
                            idx_d       = '0;
                            line_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = StIdle;
                    col_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            col_q       <= '0;
            idx_q       <= '0;
            shift_en_q  <= '0;
            pad_sel_q   <= 1'b0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            idx_q       <= idx_d;
            shift_en_q  <= shift_en_d;
            pad_sel_q   <= pad_sel_d;
            line_done_q <= line_done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign shift_en  = shift_en_q;
    assign pad_sel   = pad_sel_q;
    assign col       = col_q;
    assign line_done = line_done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_row_shift_en_gen_p.sv
// Directed bench for row_shift_en_gen_p: default config, a no-flush config and the
// TAPS=2 / ACTIVE_W=2 corner, each with its own line_start.
module tb_row_shift_en_gen_p;

    logic clk;
    logic reset_n;
    logic enable;
    logic pix_valid;
    logic ls_a, ls_b, ls_c;

    logic [10:0] shift_en_a, shift_en_b;
    logic [1:0]  shift_en_c;
    logic [12:0] col_a, col_b;
    logic [1:0]  col_c;
    logic        pad_a, pad_b, pad_c;
    logic        ld_a, ld_b, ld_c;
    logic        ov_a, ov_b, ov_c;

    int checks = 0;
    int errors = 0;

    logic [10:0] flush_exp [10] = '{11'h7FE, 11'h7FC, 11'h7F8, 11'h7F0, 11'h7E0,
                                    11'h7C0, 11'h780, 11'h700, 11'h600, 11'h400};

    row_shift_en_gen_p #(.TAPS(11), .COL_W(13), .ACTIVE_W(640), .FLUSH_EN(1'b1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .line_start(ls_a),
        .pix_valid(pix_valid), .shift_en(shift_en_a), .pad_sel(pad_a), .col(col_a),
        .line_done(ld_a), .overrun(ov_a)
    );

    row_shift_en_gen_p #(.TAPS(11), .COL_W(13), .ACTIVE_W(640), .FLUSH_EN(1'b0)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .line_start(ls_b),
        .pix_valid(pix_valid), .shift_en(shift_en_b), .pad_sel(pad_b), .col(col_b),
        .line_done(ld_b), .overrun(ov_b)
    );

    row_shift_en_gen_p #(.TAPS(2), .COL_W(2), .ACTIVE_W(2), .FLUSH_EN(1'b1)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .enable(enable), .line_start(ls_c),
        .pix_valid(pix_valid), .shift_en(shift_en_c), .pad_sel(pad_c), .col(col_c),
        .line_done(ld_c), .overrun(ov_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_shift"}, 32'(shift_en_a), 0);
        check({tag, "_pad"}, 32'(pad_a), 0);
        check({tag, "_col"}, 32'(col_a), 0);
        check({tag, "_ld"}, 32'(ld_a), 0);
        check({tag, "_ov"}, 32'(ov_a), 0);
    endtask

    // Flush of DUT a: 10 cycles of tapering mask, line_done with the last one.
    task automatic flush_a(input string tag);
        for (int k = 0; k < 10; k++) begin
            step();
            check({tag, "_fl_shift"}, 32'(shift_en_a), 32'(flush_exp[k]));
            check({tag, "_fl_pad"}, 32'(pad_a), 1);
            check({tag, "_fl_ld"}, 32'(ld_a), (k == 9) ? 1 : 0);
            check({tag, "_fl_col"}, 32'(col_a), 640);
        end
        step();
        check({tag, "_post_shift"}, 32'(shift_en_a), 0);
        check({tag, "_post_pad"}, 32'(pad_a), 0);
        check({tag, "_post_ld"}, 32'(ld_a), 0);
    endtask

    initial begin
        reset_n   = 1'b1;
        enable    = 1'b1;
        pix_valid = 1'b0;
        ls_a      = 1'b0;
        ls_b      = 1'b0;
        ls_c      = 1'b0;

        #2 reset_n = 1'b0;
        #1;
        check_a_zero("rst");
        check("rst_shift_b", 32'(shift_en_b), 0);
        check("rst_shift_c", 32'(shift_en_c), 0);
        step();
        step();
        reset_n = 1'b1;

        // No line begins without line_start.
        pix_valid = 1'b1;
        step();
        check("nostart_shift", 32'(shift_en_a), 0);
        step();
        check("nostart_col", 32'(col_a), 0);

        // Full line, continuous pixels; pixel 0 rides on line_start.
        ls_a = 1'b1;
        step();
        ls_a = 1'b0;
        check("full_col1", 32'(col_a), 1);
        check("full_shift1", 32'(shift_en_a), 32'h7FF);
        for (int i = 2; i <= 640; i++) begin
            step();
            check("full_col", 32'(col_a), i);
            check("full_shift", 32'(shift_en_a), 32'h7FF);
            check("full_ld", 32'(ld_a), 0);
        end
        flush_a("full");

        // Gapped pixels, one on / one off.
        ls_a = 1'b1;
        step();
        ls_a = 1'b0;
        check("gap_col1", 32'(col_a), 1);
        for (int c = 0; c < 1278; c++) begin
            pix_valid = (c % 2 == 1);
            step();
            check("gap_shift", 32'(shift_en_a), (c % 2 == 1) ? 32'h7FF : 0);
            check("gap_col", 32'(col_a), 1 + (c + 1) / 2);
        end
        pix_valid = 1'b0;
        flush_a("gap");

        // Overrun at col 300, then a normal line.
        ls_a      = 1'b1;
        pix_valid = 1'b1;
        step();
        ls_a = 1'b0;
        for (int i = 2; i <= 300; i++) step();
        check("ovr_col300", 32'(col_a), 300);
        ls_a      = 1'b1;
        pix_valid = 1'b0;
        step();
        ls_a = 1'b0;
        check("ovr_pulse", 32'(ov_a), 1);
        check("ovr_col0", 32'(col_a), 0);
        check("ovr_ld", 32'(ld_a), 0);
        pix_valid = 1'b1;
        step();
        check("ovr_pulse_end", 32'(ov_a), 0);
        check("ovr_col1", 32'(col_a), 1);
        for (int i = 2; i <= 640; i++) step();
        check("ovr_col640", 32'(col_a), 640);
        flush_a("ovr");

        // line_start together with the last pixel: restart, no flush.
        ls_a = 1'b1;
        step();
        ls_a = 1'b0;
        for (int i = 2; i <= 639; i++) step();
        check("last_col639", 32'(col_a), 639);
        ls_a = 1'b1;
        step();
        ls_a = 1'b0;
        check("last_col0", 32'(col_a), 0);
        check("last_ov", 32'(ov_a), 1);
        check("last_pad", 32'(pad_a), 0);
        check("last_ld", 32'(ld_a), 0);
        pix_valid = 1'b0;
        step();
        check("last_nopad", 32'(pad_a), 0);
        check("last_nold", 32'(ld_a), 0);
        check("last_ov_end", 32'(ov_a), 0);

        // Enable dropped mid-line.
        pix_valid = 1'b1;
        step();
        step();
        step();
        check("en_col3", 32'(col_a), 3);
        enable = 1'b0;
        step();
        check_a_zero("en_low");
        enable = 1'b1;
        step();
        step();
        check("en_idle_shift", 32'(shift_en_a), 0);
        check("en_idle_col", 32'(col_a), 0);

        // Asynchronous reset at flush index 4.
        ls_a = 1'b1;
        step();
        ls_a = 1'b0;
        for (int i = 2; i <= 640; i++) step();
        for (int k = 0; k < 4; k++) step();
        check("rstfl_shift", 32'(shift_en_a), 32'(flush_exp[3]));
        check("rstfl_pad", 32'(pad_a), 1);
        #3 reset_n = 1'b0;
        #1;
        check_a_zero("rstfl");
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("rstfl_after_shift", 32'(shift_en_a), 0);
            check("rstfl_after_ld", 32'(ld_a), 0);
            check("rstfl_after_ov", 32'(ov_a), 0);
        end

        // No-flush configuration.
        ls_b = 1'b1;
        step();
        ls_b = 1'b0;
        check("nf_col1", 32'(col_b), 1);
        for (int i = 2; i <= 640; i++) begin
            step();
            check("nf_col", 32'(col_b), i);
            check("nf_pad", 32'(pad_b), 0);
            check("nf_ld", 32'(ld_b), (i == 640) ? 1 : 0);
        end
        step();
        check("nf_post_ld", 32'(ld_b), 0);
        check("nf_post_shift", 32'(shift_en_b), 0);
        check("nf_post_pad", 32'(pad_b), 0);

        // TAPS=2, ACTIVE_W=2 corner.
        ls_c = 1'b1;
        step();
        ls_c = 1'b0;
        check("c_col1", 32'(col_c), 1);
        check("c_shift1", 32'(shift_en_c), 3);
        step();
        check("c_col2", 32'(col_c), 2);
        check("c_shift2", 32'(shift_en_c), 3);
        check("c_pad2", 32'(pad_c), 0);
        step();
        check("c_fl_shift", 32'(shift_en_c), 2);
        check("c_fl_pad", 32'(pad_c), 1);
        check("c_fl_ld", 32'(ld_c), 1);
        step();
        check("c_post_shift", 32'(shift_en_c), 0);
        check("c_post_pad", 32'(pad_c), 0);
        check("c_post_ld", 32'(ld_c), 0);
        pix_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
